kianv_periph_arbiter: RTL and testbench

Two-master round-robin arbiter that shares one valid/ready peripheral register port, such as the GPIO block, between the CPU data bus (m0) and a second bus master (m1, e.g. the debug/host bridge). It serialises transactions so that only one reaches the peripheral at a time. It inserts a mandatory idle cycle between grants, which absorbs the peripheral's registered, possibly repeated `ready`. It sits between the SoC address decoder and the peripheral.

---
 rtl/kianv_periph_arbiter_pkg.sv | 20 ++
 rtl/kianv_rr_pick2.sv | 13 +
 rtl/kianv_periph_arbiter.sv | 121 ++++++++++++
 tb/tb_kianv_periph_arbiter.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/kianv_periph_arbiter_pkg.sv
// Shared types and constants for the KianV peripheral-port arbiter and its round-robin picker.
package kianv_periph_arbiter_pkg;

    typedef enum logic {
        KIANV_ARB_IDLE = 1'b0,
        KIANV_ARB_BUSY = 1'b1
    } arb_state_t;

    localparam logic [31:0] KIANV_ARB_TIMEOUT_RDATA = 32'hDEAD_BEEF;
    localparam int unsigned KIANV_ARB_CNT_W         = 8;

    // last_m1 = 1 means m1 was served most recently, so m0 wins a tie.
    function automatic logic [1:0] rr_pick2(input logic valid0,
                                            input logic valid1,
                                            input logic last_m1);
        return {valid1 & (~valid0 | ~last_m1),
                valid0 & (~valid1 |  last_m1)};
    endfunction

endpackage

// File: rtl/kianv_rr_pick2.sv
// Combinational 2-way round-robin picker: one-hot pick of the requester not served last.
module kianv_rr_pick2
    import kianv_periph_arbiter_pkg::*;
(
    input  logic       valid0,
    input  logic       valid1,
    input  logic       last,
    output logic [1:0] pick
);

    assign pick = rr_pick2(valid0, valid1, last);

endmodule

// File: rtl/kianv_periph_arbiter.sv
// Two-master round-robin arbiter for a valid/ready peripheral register port.
// Define KIANV_ARB_TIMEOUT_EN to force completion after TIMEOUT_CYCLES BUSY cycles without s_ready.
module kianv_periph_arbiter
    import kianv_periph_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        m0_valid,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wstrb,
    output logic        m0_ready,
    output logic [31:0] m0_rdata,
    input  logic        m1_valid,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    output logic        m1_ready,
    output logic [31:0] m1_rdata,
    output logic        s_valid,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wstrb,
    input  logic [31:0] s_rdata,
    input  logic        s_ready,
    output logic [1:0]  grant,
    output logic        timeout_o
);

    arb_state_t  state;
    logic        last;
    logic [1:0]  pick;
    logic        busy;
    logic        tmo;
    logic        done;
    logic [31:0] resp_rdata;

    kianv_rr_pick2 u_pick (
        .valid0 (m0_valid),
        .valid1 (m1_valid),
        .last   (last),
        .pick   (pick)
    );

    assign busy = (state == KIANV_ARB_BUSY);

`ifdef KIANV_ARB_TIMEOUT_EN
    logic [KIANV_ARB_CNT_W-1:0] cnt;

    // s_ready has priority over a coinciding timeout.
    assign tmo = busy && !s_ready && (cnt == KIANV_ARB_CNT_W'(TIMEOUT_CYCLES));

    always_ff @(posedge clk) begin
        if (!resetn || !busy) begin
            cnt <= '0;
        end else if (!s_ready && !tmo) begin
            cnt <= cnt + 1'b1;
        end
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^KIANV_ARB_CNT_W'(TIMEOUT_CYCLES);
    assign tmo = 1'b0;
`endif

    assign done       = busy && (s_ready || tmo);
    assign resp_rdata = s_ready ? s_rdata : KIANV_ARB_TIMEOUT_RDATA;
    assign timeout_o  = tmo;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= KIANV_ARB_IDLE;
            grant <= '0;
            last  <= 1'b1;
        end else begin
            case (state)
                KIANV_ARB_IDLE: begin
                    if (|pick) begin
                        state <= KIANV_ARB_BUSY;
                        grant <= pick;
                        last  <= pick[1];
                    end
                end
                KIANV_ARB_BUSY: begin
                    if (done) begin
                        state <= KIANV_ARB_IDLE;
                        grant <= '0;
                    end
                end
            endcase
        end
    end

    // grant is 00 outside BUSY, so the request mux drives zeros when idle.
    always_comb begin
        s_valid  = busy;
        s_addr   = '0;
        s_wdata  = '0;
        s_wstrb  = '0;
        m0_ready = 1'b0;
        m1_ready = 1'b0;
        m0_rdata = '0;
        m1_rdata = '0;
        if (grant[0]) begin
            s_addr   = m0_addr;
            s_wdata  = m0_wdata;
            s_wstrb  = m0_wstrb;
            m0_ready = done;
            m0_rdata = done ? resp_rdata : '0;
        end else if (grant[1]) begin
            s_addr   = m1_addr;
            s_wdata  = m1_wdata;
            s_wstrb  = m1_wstrb;
            m1_ready = done;
            m1_rdata = done ? resp_rdata : '0;
        end
    end

endmodule

// File: tb/tb_kianv_periph_arbiter.sv
// Self-checking bench for kianv_periph_arbiter: directed vector table, timeout sequences, random vs reference model.
module tb_kianv_periph_arbiter;

    localparam int          TMO     = 4;
    localparam logic [31:0] RD_A5   = 32'h0000_00A5;
    localparam logic [31:0] DEAD    = 32'hDEAD_BEEF;
    localparam logic [31:0] ADDR0   = 32'h0000_0100;
    localparam logic [31:0] ADDR1   = 32'h0000_0200;

    logic        clk = 1'b0;
    logic        resetn;
    logic        m0_valid, m1_valid;
    logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
    logic [3:0]  m0_wstrb, m1_wstrb;
    logic        m0_ready, m1_ready;
    logic [31:0] m0_rdata, m1_rdata;
    logic        s_valid;
    logic [31:0] s_addr, s_wdata;
    logic [3:0]  s_wstrb;
    logic [31:0] s_rdata;
    logic        s_ready;
    logic [1:0]  grant;
    logic        timeout_o;

    int n_total = 0;
    int n_pass  = 0;

    // Reference model: owner of the port (-1 when idle), who was served last, busy-wait count.
    int m_owner = -1;
    int m_last  = 1;
    int m_cnt   = 0;

    kianv_periph_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .m0_valid  (m0_valid),
        .m0_addr   (m0_addr),
        .m0_wdata  (m0_wdata),
        .m0_wstrb  (m0_wstrb),
        .m0_ready  (m0_ready),
        .m0_rdata  (m0_rdata),
        .m1_valid  (m1_valid),
        .m1_addr   (m1_addr),
        .m1_wdata  (m1_wdata),
        .m1_wstrb  (m1_wstrb),
        .m1_ready  (m1_ready),
        .m1_rdata  (m1_rdata),
        .s_valid   (s_valid),
        .s_addr    (s_addr),
        .s_wdata   (s_wdata),
        .s_wstrb   (s_wstrb),
        .s_rdata   (s_rdata),
        .s_ready   (s_ready),
        .grant     (grant),
        .timeout_o (timeout_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit       rst;
        bit       v0;
        bit       v1;
        bit       sr;
        bit [1:0] eg;
        bit       er0;
        bit       er1;
    } vec_t;

    vec_t vecs[22];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    endtask

    function automatic bit model_tmo();
`ifdef KIANV_ARB_TIMEOUT_EN
        return (m_owner >= 0) && (m_cnt == TMO) && !s_ready;
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_update();
        if (!resetn) begin
            m_owner = -1;
            m_last  = 1;
            m_cnt   = 0;
        end else if (m_owner < 0) begin
            if (m0_valid || m1_valid) begin
                if (m0_valid && m1_valid) m_owner = 1 - m_last;
                else                      m_owner = m0_valid ? 0 : 1;
                m_last = m_owner;
                m_cnt  = 0;
            end
        end else if (s_ready || model_tmo()) begin
            m_owner = -1;
        end else begin
            m_cnt++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic check_model(input string tag);
        bit          busy, tmo, done;
        logic [1:0]  eg;
        logic [31:0] ea, ew, resp;
        logic [3:0]  es;
        busy = (m_owner >= 0);
        tmo  = model_tmo();
        done = busy && (s_ready || tmo);
        eg   = !busy ? 2'b00 : (m_owner == 0 ? 2'b01 : 2'b10);
        ea   = !busy ? 32'h0 : (m_owner == 0 ? m0_addr  : m1_addr);
        ew   = !busy ? 32'h0 : (m_owner == 0 ? m0_wdata : m1_wdata);
        es   = !busy ? 4'h0  : (m_owner == 0 ? m0_wstrb : m1_wstrb);
        resp = s_ready ? s_rdata : DEAD;
        chk({tag, " grant"},     32'(grant),     32'(eg));
        chk({tag, " s_valid"},   32'(s_valid),   32'(busy));
        chk({tag, " s_addr"},    s_addr,         ea);
        chk({tag, " s_wdata"},   s_wdata,        ew);
        chk({tag, " s_wstrb"},   32'(s_wstrb),   32'(es));
        chk({tag, " m0_ready"},  32'(m0_ready),  32'(done && m_owner == 0));
        chk({tag, " m1_ready"},  32'(m1_ready),  32'(done && m_owner == 1));
        chk({tag, " m0_rdata"},  m0_rdata,       (done && m_owner == 0) ? resp : 32'h0);
        chk({tag, " m1_rdata"},  m1_rdata,       (done && m_owner == 1) ? resp : 32'h0);
        chk({tag, " timeout_o"}, 32'(timeout_o), 32'(tmo));
    endtask

    initial begin
        resetn   = 1'b0;
        m0_valid = 1'b0; m1_valid = 1'b0;
        m0_addr  = ADDR0; m1_addr = ADDR1;
        m0_wdata = 32'h1111_0000; m1_wdata = 32'h2222_0000;
        m0_wstrb = 4'h0; m1_wstrb = 4'hF;
        s_rdata  = RD_A5;
        s_ready  = 1'b0;

        //             rst   v0    v1    sr    grant  r0    r1
        vecs[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0};  // single read
        vecs[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 1'b1, 1'b0, 1'b1, 2'b01, 1'b1, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0};  // stale ready
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0};  // reset restores last=m1
        vecs[5]  = '{1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0};  // tie after reset
        vecs[6]  = '{1'b1, 1'b1, 1'b1, 1'b0, 2'b01, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 1'b1, 1'b1, 1'b1, 2'b01, 1'b1, 1'b0};
        vecs[8]  = '{1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 1'b1, 1'b1, 1'b1, 2'b10, 1'b0, 1'b1};
        vecs[11] = '{1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0};
        vecs[12] = '{1'b1, 1'b1, 1'b1, 1'b0, 2'b01, 1'b0, 1'b0};
        vecs[13] = '{1'b1, 1'b1, 1'b1, 1'b1, 2'b01, 1'b1, 1'b0};
        vecs[14] = '{1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0};
        vecs[15] = '{1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0};  // reset mid-BUSY
        vecs[16] = '{1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 1'b0};
        vecs[17] = '{1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0};
        vecs[18] = '{1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0};
        vecs[19] = '{1'b1, 1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0};  // s_ready ignored in IDLE
        vecs[20] = '{1'b1, 1'b1, 1'b0, 1'b1, 2'b01, 1'b1, 1'b0};
        vecs[21] = '{1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0};

        tick(); tick(); tick();
        #3;
        chk("reset grant",    32'(grant),     32'h0);
        chk("reset s_valid",  32'(s_valid),   32'h0);
        chk("reset s_addr",   s_addr,         32'h0);
        chk("reset m0_ready", 32'(m0_ready),  32'h0);
        chk("reset m1_ready", 32'(m1_ready),  32'h0);
        chk("reset timeout",  32'(timeout_o), 32'h0);
        resetn = 1'b1;
        tick();

        for (int i = 0; i < 22; i++) begin
            string t;
            logic [31:0] eaddr;
            resetn   = vecs[i].rst;
            m0_valid = vecs[i].v0;
            m1_valid = vecs[i].v1;
            s_ready  = vecs[i].sr;
            #3;
            t = $sformatf("vec%0d", i);
            eaddr = vecs[i].eg == 2'b01 ? ADDR0 : (vecs[i].eg == 2'b10 ? ADDR1 : 32'h0);
            chk({t, " grant"},    32'(grant),    32'(vecs[i].eg));
            chk({t, " s_valid"},  32'(s_valid),  32'(|vecs[i].eg));
            chk({t, " s_addr"},   s_addr,        eaddr);
            chk({t, " m0_ready"}, 32'(m0_ready), 32'(vecs[i].er0));
            chk({t, " m1_ready"}, 32'(m1_ready), 32'(vecs[i].er1));
            chk({t, " m0_rdata"}, m0_rdata,      vecs[i].er0 ? RD_A5 : 32'h0);
            chk({t, " m1_rdata"}, m1_rdata,      vecs[i].er1 ? RD_A5 : 32'h0);
            tick();
        end

`ifdef KIANV_ARB_TIMEOUT_EN
        // Peripheral never answers: forced completion in the 5th BUSY cycle.
        resetn = 1'b0; m0_valid = 1'b0; m1_valid = 1'b0; s_ready = 1'b0;
        tick();
        resetn = 1'b1; m0_valid = 1'b1;
        tick();
        for (int c = 0; c < TMO; c++) begin
            #3;
            chk($sformatf("tmo wait%0d m0_ready", c), 32'(m0_ready),  32'h0);
            chk($sformatf("tmo wait%0d timeout", c),  32'(timeout_o), 32'h0);
            tick();
        end
        #3;
        chk("tmo m0_ready", 32'(m0_ready),  32'h1);
        chk("tmo timeout",  32'(timeout_o), 32'h1);
        chk("tmo m0_rdata", m0_rdata,       DEAD);
        tick();
        m0_valid = 1'b0;
        #3;
        chk("tmo idle grant", 32'(grant), 32'h0);
        // s_ready lands on the timeout cycle: normal completion wins.
        m0_valid = 1'b1;
        tick();
        for (int c = 0; c < TMO; c++) tick();
        s_ready = 1'b1;
        #3;
        chk("race m0_ready", 32'(m0_ready),  32'h1);
        chk("race timeout",  32'(timeout_o), 32'h0);
        chk("race m0_rdata", m0_rdata,       RD_A5);
        tick();
        m0_valid = 1'b0; s_ready = 1'b0;
        tick();
`endif

        for (int i = 0; i < 500; i++) begin
            resetn   = ($urandom_range(0, 49) != 0);
            m0_valid = $urandom_range(0, 1) == 1;
            m1_valid = $urandom_range(0, 1) == 1;
            m0_addr  = $urandom;  m1_addr  = $urandom;
            m0_wdata = $urandom;  m1_wdata = $urandom;
            m0_wstrb = 4'($urandom); m1_wstrb = 4'($urandom);
            s_rdata  = $urandom;
            s_ready  = ($urandom_range(0, 9) < 4);
            #3;
            check_model($sformatf("rnd%0d", i));
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1);
    end

endmodule
